// File: rtl/mmio_io_pkg.sv
`default_nettype none
// mmio_io_pkg: register map, TCTL bit positions and 7-segment encoding for mmio_io_ctrl.  Rev 1.0
package mmio_io_pkg;

  typedef logic [5:0] io_off_t;

  localparam io_off_t OFF_HEX     = 6'h00;
  localparam io_off_t OFF_LEDR    = 6'h04;
  localparam io_off_t OFF_LEDG    = 6'h08;
  localparam io_off_t OFF_KEY     = 6'h10;
  localparam io_off_t OFF_SW      = 6'h14;
  localparam io_off_t OFF_KEYSTAT = 6'h18;
  localparam io_off_t OFF_TCNT    = 6'h20;
  localparam io_off_t OFF_TLIM    = 6'h24;
  localparam io_off_t OFF_TCTL    = 6'h28;

  localparam int TCTL_EN_BIT  = 0;
  localparam int TCTL_OVF_BIT = 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/io_debounce.sv
`default_nettype none
// io_debounce: one-bit two-flop synchroniser followed by a consecutive-difference debouncer.  Rev 1.0
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic dout_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1_q, sync2_q, db_q;
  logic [CW-1:0] cnt_q;

  // The output flips on the cycle after the synchronised input has disagreed
  // with it for DEBOUNCE_CYCLES cycles in a row; any agreement restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      if (sync2_q == db_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
        db_q  <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout_o = db_q;

endmodule
`default_nettype wire

// File: rtl/mmio_io_ctrl.sv
`default_nettype none
// mmio_io_ctrl: memory-mapped HEX/LED/KEY/SW controller with debounced inputs and sticky key capture.
// Optional free-running timer built when MMIO_IO_TIMER_EN is defined.  Rev 1.0
module mmio_io_ctrl
  import mmio_io_pkg::*;
#(
  parameter int               DBITS           = 32,
  parameter logic [DBITS-1:0] IO_BASE         = 32'hF000_0000,
  parameter int               NUM_HEX         = 4,
  parameter int               NUM_LEDR        = 10,
  parameter int               NUM_LEDG        = 8,
  parameter int               NUM_SW          = 10,
  parameter int               NUM_KEY         = 4,
  parameter int               DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DBITS-1:0]     addr,
  input  logic                 wr_en,
  input  logic [DBITS-1:0]     wdata,
  output logic [DBITS-1:0]     rdata,
  output logic                 hit,
  input  logic [NUM_SW-1:0]    sw,
  input  logic [NUM_KEY-1:0]   key,
  output logic [NUM_LEDR-1:0]  ledr,
  output logic [NUM_LEDG-1:0]  ledg,
  output logic [7*NUM_HEX-1:0] hex,
  output logic                 irq
);

  logic                   w_hit, w_we, w_ovf, w_unused;
  io_off_t                w_off;
  logic [NUM_KEY-1:0]     w_key_db, w_key_rise;
  logic [NUM_SW-1:0]      w_sw_db;

  logic [4*NUM_HEX-1:0]   hex_q, hex_d;
  logic [NUM_LEDR-1:0]    ledr_q, ledr_d;
  logic [NUM_LEDG-1:0]    ledg_q, ledg_d;
  logic [NUM_KEY-1:0]     keystat_q, keystat_d;
  logic [NUM_KEY-1:0]     key_db_prev_q;

  assign w_hit    = (addr[DBITS-1:6] == IO_BASE[DBITS-1:6]);
  assign w_off    = addr[5:0];
  assign w_we     = wr_en & w_hit;
  assign hit      = w_hit;
  assign w_unused = &{1'b0, wdata};

  // Keys are active-low on the pins; the debounced view is 1 = pressed.
  for (genvar i = 0; i < NUM_KEY; i++) begin : g_key_db
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (reset),
      .din_i (~key[i]),
      .dout_o(w_key_db[i])
    );
  end

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_db
    io_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (reset),
      .din_i (sw[i]),
      .dout_o(w_sw_db[i])
    );
  end

  assign w_key_rise = w_key_db & ~key_db_prev_q;

  always_comb begin
    hex_d     = hex_q;
    ledr_d    = ledr_q;
    ledg_d    = ledg_q;
    keystat_d = keystat_q;
    if (w_we) begin
      case (w_off)
        OFF_HEX:     hex_d     = wdata[4*NUM_HEX-1:0];
        OFF_LEDR:    ledr_d    = wdata[NUM_LEDR-1:0];
        OFF_LEDG:    ledg_d    = wdata[NUM_LEDG-1:0];
        OFF_KEYSTAT: keystat_d = keystat_q & ~wdata[NUM_KEY-1:0];
        default:     ;
      endcase
    end
    // A new press beats a simultaneous clear.
    keystat_d = keystat_d | w_key_rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hex_q         <= '0;
      ledr_q        <= '0;
      ledg_q        <= '0;
      keystat_q     <= '0;
      key_db_prev_q <= '0;
    end else begin
      hex_q         <= hex_d;
      ledr_q        <= ledr_d;
      ledg_q        <= ledg_d;
      keystat_q     <= keystat_d;
      key_db_prev_q <= w_key_db;
    end
  end

`ifdef MMIO_IO_TIMER_EN
  logic [DBITS-1:0] tcnt_q, tcnt_d, tlim_q, tlim_d, w_lim;
  logic             ten_q, ten_d, ovf_q, ovf_d, w_wrap;

  assign w_lim = (tlim_q == '0) ? '1 : tlim_q;

  always_comb begin
    tcnt_d = tcnt_q;
    tlim_d = tlim_q;
    ten_d  = ten_q;
    ovf_d  = ovf_q;
    w_wrap = 1'b0;
    if (ten_q) begin
      if (tcnt_q == w_lim) begin
        tcnt_d = '0;
        w_wrap = 1'b1;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
    // A CPU write to TCNT replaces both the increment and any wrap.
    if (w_we && w_off == OFF_TCNT) begin
      tcnt_d = wdata;
      w_wrap = 1'b0;
    end
    if (w_we && w_off == OFF_TLIM) tlim_d = wdata;
    if (w_we && w_off == OFF_TCTL) begin
      ten_d = wdata[TCTL_EN_BIT];
      if (wdata[TCTL_OVF_BIT]) ovf_d = 1'b0;
    end
    if (w_wrap) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt_q <= '0;
      tlim_q <= '0;
      ten_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tlim_q <= tlim_d;
      ten_q  <= ten_d;
      ovf_q  <= ovf_d;
    end
  end

  assign w_ovf = ovf_q;
`else
  assign w_ovf = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (w_hit) begin
      case (w_off)
        OFF_HEX:     rdata[4*NUM_HEX-1:0] = hex_q;
        OFF_LEDR:    rdata[NUM_LEDR-1:0]  = ledr_q;
        OFF_LEDG:    rdata[NUM_LEDG-1:0]  = ledg_q;
        OFF_KEY:     rdata[NUM_KEY-1:0]   = w_key_db;
        OFF_SW:      rdata[NUM_SW-1:0]    = w_sw_db;
        OFF_KEYSTAT: rdata[NUM_KEY-1:0]   = keystat_q;
`ifdef MMIO_IO_TIMER_EN
        OFF_TCNT:    rdata = tcnt_q;
        OFF_TLIM:    rdata = tlim_q;
        OFF_TCTL: begin
          rdata[TCTL_EN_BIT]  = ten_q;
          rdata[TCTL_OVF_BIT] = ovf_q;
        end
`endif
        default:     rdata = '0;
      endcase
    end
  end

  for (genvar d = 0; d < NUM_HEX; d++) begin : g_hex
    assign hex[7*d +: 7] = hex_to_seg(hex_q[4*d +: 4]);
  end

  assign ledr = ledr_q;
  assign ledg = ledg_q;
  assign irq  = (|keystat_q) | w_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mmio_io_ctrl.sv
`default_nettype none
// tb_mmio_io_ctrl: directed and randomized checks of mmio_io_ctrl against a cycle-level reference model.
module tb_mmio_io_ctrl;

  localparam int          DBITS   = 32;
  localparam logic [31:0] IO_BASE = 32'hF000_0000;
  localparam int          DC      = 16;
  localparam int          HMAX    = 8192;

  // Lit segments (active-high, gfedcba) for 0..F; the pins are the complement.
  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  localparam logic [5:0] OFFS [12] = '{6'h00, 6'h04, 6'h08, 6'h10, 6'h14, 6'h18,
                                       6'h20, 6'h24, 6'h28, 6'h0C, 6'h2C, 6'h3C};

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr  = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic [9:0]  sw    = '0;
  logic [3:0]  key   = 4'hF;
  logic [31:0] rdata;
  logic        hit;
  logic [9:0]  ledr;
  logic [7:0]  ledg;
  logic [27:0] hex;
  logic        irq;

  always #5 clk = ~clk;

  mmio_io_ctrl #(
    .DBITS(DBITS), .IO_BASE(IO_BASE), .NUM_HEX(4), .NUM_LEDR(10), .NUM_LEDG(8),
    .NUM_SW(10), .NUM_KEY(4), .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata), .rdata(rdata),
    .hit(hit), .sw(sw), .key(key), .ledr(ledr), .ledg(ledg), .hex(hex), .irq(irq)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_hex;
  logic [9:0]  m_ledr, m_sdb;
  logic [7:0]  m_ledg;
  logic [3:0]  m_keystat, m_kdb, m_krise;
  logic [31:0] m_tcnt, m_tlim;
  logic        m_ten, m_ovf;
  bit   [3:0]  kp [HMAX];
  bit   [9:0]  sp [HMAX];
  int          hn;

  task automatic model_reset();
    m_hex = '0; m_ledr = '0; m_ledg = '0; m_keystat = '0; m_kdb = '0; m_sdb = '0;
    m_krise = '0; m_tcnt = '0; m_tlim = '0; m_ten = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < HMAX; i++) begin
      kp[i] = '0;
      sp[i] = '0;
    end
    hn = DC + 4;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:6] == IO_BASE[31:6];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    case (a[5:0])
      6'h00: r[15:0] = m_hex;
      6'h04: r[9:0]  = m_ledr;
      6'h08: r[7:0]  = m_ledg;
      6'h10: r[3:0]  = m_kdb;
      6'h14: r[9:0]  = m_sdb;
      6'h18: r[3:0]  = m_keystat;
`ifdef MMIO_IO_TIMER_EN
      6'h20: r       = m_tcnt;
      6'h24: r       = m_tlim;
      6'h28: r[1:0]  = {m_ovf, m_ten};
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] m_hexpins();
    logic [27:0] r;
    for (int d = 0; d < 4; d++) r[7*d +: 7] = ~SEG_ON[m_hex[4*d +: 4]];
    return r;
  endfunction

  function automatic logic m_irq();
`ifdef MMIO_IO_TIMER_EN
    return (|m_keystat) | m_ovf;
`else
    return |m_keystat;
`endif
  endfunction

  // One clock edge: p[n] is the pin level sampled at edge n; it reaches the
  // debouncer two edges later, and the debounced level flips once it has
  // seen DC+1 consecutive disagreeing samples.
  task automatic model_step(input logic [31:0] a, input logic we, input logic [31:0] d,
                            input logic [3:0] kpin, input logic [9:0] spin);
    logic       w;
    logic [5:0] off;
    logic [3:0] nks, nkdb;
    logic [9:0] nsdb;
    bit         all;
    w   = we && m_hit(a);
    off = a[5:0];
    nks = m_keystat;
    if (w && off == 6'h18) nks = nks & ~d[3:0];
    nks = nks | m_krise;
    hn++;
    kp[hn] = ~kpin;
    sp[hn] = spin;
    nkdb = m_kdb;
    for (int b = 0; b < 4; b++) begin
      all = 1'b1;
      for (int j = hn - 2 - DC; j <= hn - 2; j++) if (kp[j][b] == m_kdb[b]) all = 1'b0;
      if (all) nkdb[b] = ~m_kdb[b];
    end
    nsdb = m_sdb;
    for (int b = 0; b < 10; b++) begin
      all = 1'b1;
      for (int j = hn - 2 - DC; j <= hn - 2; j++) if (sp[j][b] == m_sdb[b]) all = 1'b0;
      if (all) nsdb[b] = ~m_sdb[b];
    end
    m_krise   = nkdb & ~m_kdb;
    m_kdb     = nkdb;
    m_sdb     = nsdb;
    m_keystat = nks;
    if (w && off == 6'h00) m_hex  = d[15:0];
    if (w && off == 6'h04) m_ledr = d[9:0];
    if (w && off == 6'h08) m_ledg = d[7:0];
`ifdef MMIO_IO_TIMER_EN
    begin
      logic [31:0] lim, nc;
      bit          wrap;
      lim  = (m_tlim == 0) ? 32'hFFFF_FFFF : m_tlim;
      nc   = m_tcnt;
      wrap = 1'b0;
      if (w && off == 6'h20) nc = d;
      else if (m_ten) begin
        if (m_tcnt == lim) begin
          nc   = 0;
          wrap = 1'b1;
        end else nc = m_tcnt + 1;
      end
      if (w && off == 6'h28 && d[1]) m_ovf = 1'b0;
      if (wrap) m_ovf = 1'b1;
      if (w && off == 6'h28) m_ten = d[0];
      if (w && off == 6'h24) m_tlim = d;
      m_tcnt = nc;
    end
`endif
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check_all();
    chk("hit", 64'(hit), 64'(m_hit(addr)));
    if (m_hit(addr)) chk($sformatf("rdata@%02h", addr[5:0]), 64'(rdata), 64'(m_read(addr)));
    chk("hex", 64'(hex), 64'(m_hexpins()));
    chk("ledr", 64'(ledr), 64'(m_ledr));
    chk("ledg", 64'(ledg), 64'(m_ledg));
    chk("irq", 64'(irq), 64'(m_irq()));
  endtask

  task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] d);
    addr  = a;
    wr_en = we;
    wdata = d;
    #1;
    check_all();
    @(posedge clk);
    model_step(a, we, d, key, sw);
    #1;
  endtask

  task automatic peek(input logic [31:0] a);
    addr  = a;
    wr_en = 1'b0;
    #1;
  endtask

  int          khold = 0;
  int          shold = 0;
  int          r;
  logic [31:0] ra, rd;
  logic        rw;

  initial begin
    model_reset();
    #26 reset = 1'b1;

    peek(IO_BASE);          chk("rst_hexreg", 64'(rdata), 64'd0);
    peek(IO_BASE + 32'h04); chk("rst_ledrreg", 64'(rdata), 64'd0);
    peek(IO_BASE + 32'h18); chk("rst_keystat", 64'(rdata), 64'd0);
    chk("rst_hexpins", 64'(hex), 64'({4{7'h40}}));
    chk("rst_irq", 64'(irq), 64'd0);

    cyc(IO_BASE, 1'b1, 32'h0000_A5F3);
    peek(IO_BASE);
    chk("hex_readback", 64'(rdata), 64'h0000_A5F3);
    chk("hex_digits", 64'(hex), 64'({7'h08, 7'h12, 7'h0E, 7'h30}));

    // KEY[2] held pressed: debounced after 2 + DC + 1 edges.
    key = 4'b1011;
    repeat (18) cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
    peek(IO_BASE + 32'h10); chk("key_lat18", 64'(rdata), 64'h0);
    cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
    peek(IO_BASE + 32'h10); chk("key_lat19", 64'(rdata), 64'h4);
    cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
    peek(IO_BASE + 32'h18); chk("keystat_set", 64'(rdata), 64'h4);
    chk("irq_key", 64'(irq), 64'd1);
    cyc(IO_BASE + 32'h18, 1'b1, 32'h4);
    chk("irq_w1c", 64'(irq), 64'd0);

    // KEY[0] bouncing every 5 cycles never settles.
    for (int i = 0; i < 60; i++) begin
      if (i % 5 == 0) key[0] = ~key[0];
      cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
      peek(IO_BASE + 32'h10); chk("key0_bounce", 64'(rdata[0]), 64'd0);
    end
    peek(IO_BASE + 32'h18); chk("keystat_bounce", 64'(rdata), 64'd0);
    key = 4'hF;

`ifdef MMIO_IO_TIMER_EN
    begin
      int exp_seq [5] = '{0, 1, 2, 3, 0};
      cyc(IO_BASE + 32'h24, 1'b1, 32'd3);
      cyc(IO_BASE + 32'h20, 1'b1, 32'd0);
      cyc(IO_BASE + 32'h28, 1'b1, 32'd1);
      for (int i = 0; i < 5; i++) begin
        peek(IO_BASE + 32'h20); chk("tcnt_seq", 64'(rdata), 64'(exp_seq[i]));
        if (i < 4) cyc(IO_BASE + 32'h20, 1'b0, 32'h0);
      end
      peek(IO_BASE + 32'h28); chk("ovf_on_wrap", 64'(rdata), 64'h3);
      repeat (3) cyc(IO_BASE + 32'h20, 1'b0, 32'h0);
      cyc(IO_BASE + 32'h28, 1'b1, 32'h3);
      peek(IO_BASE + 32'h28); chk("ovf_set_wins", 64'(rdata), 64'h3);
      peek(IO_BASE + 32'h20); chk("tcnt_wrapped", 64'(rdata), 64'h0);
      cyc(IO_BASE + 32'h28, 1'b1, 32'h2);
      chk("irq_ovf_clr", 64'(irq), 64'd0);
    end
`else
    cyc(IO_BASE + 32'h20, 1'b1, 32'hFFFF_FFFF);
    cyc(IO_BASE + 32'h28, 1'b1, 32'hFFFF_FFFF);
    peek(IO_BASE + 32'h20); chk("notimer_tcnt", 64'(rdata), 64'h0);
    peek(IO_BASE + 32'h28); chk("notimer_tctl", 64'(rdata), 64'h0);
    chk("notimer_irq", 64'(irq), 64'd0);
`endif

    cyc(IO_BASE + 32'h04, 1'b1, 32'h155);
    cyc(IO_BASE + 32'h2C, 1'b1, 32'hFFFF_FFFF);
    peek(IO_BASE + 32'h40); chk("hit_outside", 64'(hit), 64'd0);
    cyc(IO_BASE + 32'h40, 1'b1, 32'hFFFF_FFFF);
    peek(IO_BASE + 32'h04); chk("ledr_kept", 64'(rdata), 64'h155);
    peek(IO_BASE);          chk("hex_kept", 64'(rdata), 64'h0000_A5F3);

    for (int c = 0; c < 1500; c++) begin
      if (khold == 0) begin
        key   = 4'($urandom);
        khold = $urandom_range(1, 30);
      end else khold--;
      if (shold == 0) begin
        sw    = 10'($urandom);
        shold = $urandom_range(1, 40);
      end else shold--;
      r = $urandom_range(0, 15);
      if (r == 0)      ra = $urandom;
      else if (r == 1) ra = IO_BASE + 32'h40 + 32'($urandom_range(0, 255));
      else if (r == 2) ra = IO_BASE + 32'($urandom_range(0, 63));
      else             ra = IO_BASE + {26'd0, OFFS[$urandom_range(0, 11)]};
      case (ra[5:0])
        6'h20:   rd = 32'($urandom_range(0, 40));
        6'h24:   rd = 32'($urandom_range(0, 12));
        6'h28:   rd = 32'($urandom_range(0, 3));
        default: rd = $urandom;
      endcase
      rw = ($urandom_range(0, 2) == 0);
      cyc(ra, rw, rd);
    end

    // Reset asserted while a key is mid-debounce and the timer may be running.
    key = 4'b1101;
    cyc(IO_BASE + 32'h04, 1'b1, 32'h3FF);
    repeat (10) cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
    addr  = IO_BASE + 32'h04;
    wr_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("arst_hex", 64'(hex), 64'({4{7'h40}}));
    chk("arst_ledr", 64'(ledr), 64'd0);
    chk("arst_ledg", 64'(ledg), 64'd0);
    chk("arst_irq", 64'(irq), 64'd0);
    chk("arst_rdata", 64'(rdata), 64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (25) cyc(IO_BASE + 32'h10, 1'b0, 32'h0);
    peek(IO_BASE + 32'h10); chk("key_after_rst", 64'(rdata), 64'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Parametrised memory-mapped I/O controller for the single-cycle core. It generalises the fixed KEY/SW/HEX/LEDR/LEDG map to configurable channel counts and adds several features: two-flop input synchronisation, per-input debouncing, sticky key-press capture with write-1-to-clear, and an optional free-running timer. It sits beside data memory on the core's load/store path and claims addresses in the window at `IO_BASE`.

## Interface
- `DBITS`, 32, data/address width
- `IO_BASE`, 32'hF0000000, base of the 64-byte I/O window
- `NUM_HEX`, 4, seven-segment digits
- `NUM_LEDR`, 10, red LEDs
- `NUM_LEDG`, 8, green LEDs
- `NUM_SW`, 10, switches
- `NUM_KEY`, 4, push buttons (active-low pins)
- `DEBOUNCE_CYCLES`, 16, stable cycles before a debounced input changes (≥1)

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-low reset
- `addr`  in  DBITS  byte address from the ALU
- `wr_en`  in  1  store strobe
- `wdata`  in  DBITS  store data
- `rdata`  out  DBITS  load data, combinational from `addr`
- `hit`  out  1  `addr` is inside the 64-byte window
- `sw`  in  NUM_SW  raw switches
- `key`  in  NUM_KEY  raw keys, 0 = pressed
- `ledr`  out  NUM_LEDR  red LEDs
- `ledg`  out  NUM_LEDG  green LEDs
- `hex`  out  7*NUM_HEX  active-low segments; digit i occupies bits [7i+6:7i]
- `irq`  out  1  OR of all sticky status bits

## Operation
- Register offsets from `IO_BASE`:
  - 0x00 HEX: 4-bit nibble per digit, R/W.
  - 0x04 LEDR: R/W.
  - 0x08 LEDG: R/W.
  - 0x10 KEY: debounced level, 1 = pressed, RO.
  - 0x14 SW: debounced level, RO.
  - 0x18 KEYSTAT: sticky press bits, W1C.
  - 0x20 TCNT: R/W.
  - 0x24 TLIM: R/W.
  - 0x28 TCTL: bit0 enable, bit1 overflow sticky (W1C).
- Unmapped offsets inside the window read 0; writes to them are ignored. Unused upper bits read 0.
- Writes take effect only when `wr_en` and `hit` are both high.
- Every `sw`/`key` bit passes through a 2-flop synchroniser and then a debouncer. The debounced value updates only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the counter.
- A rising edge of debounced KEY[i] sets KEYSTAT[i]. If a set and a W1C clear land in the same cycle, the set wins.
- Each HEX nibble drives a hex-digit decoder for 0–F, active-low.
- Timer:
  - When enabled, TCNT increments every cycle.
  - When TCNT == TLIM, the next value is 0 and TCTL.ovf is set.
  - TLIM = 0 means wrap at all-ones (TLIM = 0 is treated as 2^DBITS−1).
  - A CPU write to TCNT overrides the increment and wrap in that cycle. An ovf set and an ovf clear in the same cycle resolve to set.
- `irq` = |KEYSTAT | TCTL.ovf.

## Timing
- Reset (async assert, sync release):
  - All registers 0.
  - Debounced KEY and SW are 0 (not pressed).
  - `hex` = 7'b1000000 per digit ("0").
  - `ledr`, `ledg`, and `irq` are 0.
- Read: zero latency, combinational. Write: visible on outputs and `rdata` the next cycle.
- Pin-to-KEY/SW latency: 2 synchroniser cycles + `DEBOUNCE_CYCLES` + 1.
- KEYSTAT is set 1 cycle after the debounced rising edge. `irq` follows combinationally from the sticky bits.
- Asserting reset mid-count aborts debounce and timer state immediately.

## Configuration
- `MMIO_IO_TIMER_EN` defined: TCNT, TLIM and TCTL exist as described.
- Not defined:
  - No timer logic is built.
  - Offsets 0x20–0x28 read 0 and ignore writes.
  - `irq` = |KEYSTAT.

## Structure
- Package `mmio_io_pkg`: register offset constants, TCTL bit indices, and the 7-segment encoding constant for blank/0.
- Sub-module `io_debounce`: a one-bit synchroniser plus debouncer, parametrised by `DEBOUNCE_CYCLES` and instantiated per input bit.

## Test plan
- Reset deasserted, read 0x00/0x04/0x18 → 0. Every `hex` digit = 7'h40.
- Write 0x00 ← 32'h0000_A5F3 → digits 3..0 show A,5,F,3 next cycle. Read back = 32'h0000_A5F3.
- KEY[2] held low 18 cycles with `DEBOUNCE_CYCLES` = 16 → KEY reads 4'b0100 at cycle 19, KEYSTAT[2] = 1, `irq` = 1. Write 0x18 ← 4 → `irq` = 0.
- KEY[0] toggled every 5 cycles → debounced KEY[0] never changes and KEYSTAT stays 0.
- Timer (`MMIO_IO_TIMER_EN` defined): TLIM = 3, TCTL = 1 → TCNT reads 0,1,2,3,0 and ovf sets on the wrap. A W1C clear in the same cycle as the next wrap leaves ovf = 1.
- Write to 0x2C and to `IO_BASE` + 0x40 → no register changes. `hit` = 0 for the latter.
